// File: rtl/fetch_predict_stage_pkg.sv
// Shared constants and types for the fetch/predict stage and its BTB.
// Holds the bubble instruction, counter encodings and index-width helper.
// No logic of its own.
package fetch_predict_stage_pkg;

  localparam logic [31:0] DEF_NOP_INST = 32'h3b000099;
  localparam int          INST_BYTES   = 4;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_predict_stage_btb.sv
// Direct-mapped BTB with 2-bit direction counters, addressed by word PC.
// Lookup is combinational; update lands on the next clock edge.
// No backpressure: an update is accepted on every cycle it is presented.
module fetch_btb
  import fetch_predict_stage_pkg::*;
#(
  parameter int DBITS   = 32,
  parameter int ENTRIES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-3:0] lookup_word,
  output logic             lookup_taken,
  output logic [DBITS-1:0] lookup_target,
  input  logic             upd_en,
  input  logic [DBITS-3:0] upd_word,
  input  logic             upd_taken,
  input  logic [DBITS-1:0] upd_target
);

  localparam int IDXW = clog2(ENTRIES);
  localparam int TAGW = DBITS - 2 - IDXW;

  logic             entry_vld [ENTRIES];
  logic [TAGW-1:0]  tag_q     [ENTRIES];
  logic [DBITS-1:0] target_q  [ENTRIES];
  ctr_t             ctr_q     [ENTRIES];

  logic [IDXW-1:0] lk_idx, up_idx;
  logic [TAGW-1:0] lk_tag, up_tag;
  logic            lk_hit, up_hit;

  assign lk_idx = lookup_word[IDXW-1:0];
  assign lk_tag = lookup_word[DBITS-3:IDXW];
  assign up_idx = upd_word[IDXW-1:0];
  assign up_tag = upd_word[DBITS-3:IDXW];

  assign lk_hit        = entry_vld[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit        = entry_vld[up_idx] && (tag_q[up_idx] == up_tag);
  assign lookup_taken  = lk_hit && ctr_q[lk_idx][1];
  assign lookup_target = target_q[lk_idx];

  // Tags and targets are only meaningful behind a valid bit, so they skip reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_vld[i] <= 1'b0;
        ctr_q[i]     <= CTR_WNT;
      end
    end else if (upd_en) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (ctr_q[up_idx] != CTR_ST) ctr_q[up_idx] <= ctr_t'(ctr_q[up_idx] + 2'd1);
          target_q[up_idx] <= upd_target;
        end else if (ctr_q[up_idx] != CTR_SNT) begin
          ctr_q[up_idx] <= ctr_t'(ctr_q[up_idx] - 2'd1);
        end
      end else if (upd_taken) begin
        entry_vld[up_idx] <= 1'b1;
        tag_q[up_idx]     <= up_tag;
        target_q[up_idx]  <= upd_target;
        ctr_q[up_idx]     <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/fetch_predict_stage.sv
// Instruction fetch with BTB prediction, exec-driven redirect and flush.
// Latency: word at imem_addr appears on pc/instruction one cycle later.
// Backpressure: stall freezes fetch PC and outputs; a mispredict still redirects.
module fetch_predict_stage
  import fetch_predict_stage_pkg::*;
#(
  parameter int               DBITS       = 32,
  parameter logic [DBITS-1:0] START_PC    = DBITS'(64),
  parameter int               BTB_ENTRIES = 16,
  parameter logic [DBITS-1:0] NOP_INST    = DBITS'(DEF_NOP_INST)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [DBITS-1:0] imem_addr,
  input  logic [DBITS-1:0] imem_data,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic [DBITS-1:0] ex_pc,
  input  logic             ex_taken,
  input  logic [DBITS-1:0] ex_target,
  input  logic             ex_pred_taken,
  input  logic [DBITS-1:0] ex_pred_target,
  output logic [DBITS-1:0] pc,
  output logic [DBITS-1:0] instruction,
  output logic             valid,
  output logic             pred_taken,
  output logic [DBITS-1:0] pred_target,
  output logic             flush
);

  localparam logic [DBITS-1:0] STEP = DBITS'(INST_BYTES);

  logic [DBITS-1:0] fpc, next_fpc, redirect_pc, lk_target;
  logic             lk_taken, mispredict;

  fetch_btb #(
    .DBITS  (DBITS),
    .ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .reset        (reset),
    .lookup_word  (fpc[DBITS-1:2]),
    .lookup_taken (lk_taken),
    .lookup_target(lk_target),
    .upd_en       (ex_valid),
    .upd_word     (ex_pc[DBITS-1:2]),
    .upd_taken    (ex_taken),
    .upd_target   (ex_target)
  );

  assign imem_addr   = fpc;
  assign mispredict  = ex_valid &&
                       ((ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target)));
  assign flush       = mispredict;
  // pred_target carries the predicted next fetch address, taken or not.
  assign next_fpc    = lk_taken ? lk_target : fpc + STEP;
  assign redirect_pc = ex_taken ? ex_target : ex_pc + STEP;

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc         <= START_PC;
      pc          <= '0;
      instruction <= NOP_INST;
      valid       <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (mispredict) begin
      fpc         <= redirect_pc;
      valid       <= 1'b0;
      instruction <= NOP_INST;
    end else if (!stall) begin
      pc          <= fpc;
      instruction <= imem_data;
      valid       <= 1'b1;
      pred_taken  <= lk_taken;
      pred_target <= next_fpc;
      fpc         <= next_fpc;
    end
  end

endmodule

// File: tb/tb_fetch_predict_stage.sv
// Directed scenarios plus random traffic against a behavioural fetch/BTB model.
module tb_fetch_predict_stage;

  localparam logic [31:0] NOP = 32'h3b000099;

  logic        clk = 1'b0;
  logic        reset, stall, ex_valid, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target, imem_data, imem_addr;
  logic [31:0] pc, instruction, pred_target;
  logic        valid, pred_taken, flush;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_predict_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc(pc), .instruction(instruction), .valid(valid), .pred_taken(pred_taken),
    .pred_target(pred_target), .flush(flush)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: fetch state plus a BTB keyed by (pc/4) mod 16, tag pc/64.
  logic [31:0] m_fpc, m_pc, m_inst, m_ptgt;
  bit          m_valid, m_pt, m_ok = 0;
  bit          b_vld [16];
  logic [31:0] b_tag [16];
  logic [31:0] b_tgt [16];
  int          b_ctr [16];

  function automatic bit model_pred(input logic [31:0] a);
    int i;
    i = (a / 4) % 16;
    return b_vld[i] && b_tag[i] == a / 64 && b_ctr[i] >= 2;
  endfunction

  task automatic step(input bit rst, input bit st, input bit ev, input logic [31:0] epc,
                      input bit et, input logic [31:0] etg, input bit ept, input logic [31:0] eptg);
    bit          mis, ptk;
    int          li, ui;
    logic [31:0] nxt;
    @(negedge clk);
    reset = rst; stall = st; ex_valid = ev; ex_pc = epc; ex_taken = et;
    ex_target = etg; ex_pred_taken = ept; ex_pred_target = eptg;
    #1;
    mis = ev && (et != ept || (et && etg != eptg));
    check_eq("flush", flush, mis);
    if (m_ok) begin
      check_eq("imem_addr", imem_addr, m_fpc);
      check_eq("valid", valid, m_valid);
      check_eq("pc", pc, m_pc);
      check_eq("instruction", instruction, m_inst);
      check_eq("pred_taken", pred_taken, m_pt);
      check_eq("pred_target", pred_target, m_ptgt);
    end
    li  = (m_fpc / 4) % 16;
    ptk = model_pred(m_fpc);
    nxt = ptk ? b_tgt[li] : m_fpc + 4;
    if (rst) begin
      m_fpc = 64; m_pc = 0; m_inst = NOP; m_valid = 0; m_pt = 0; m_ptgt = 0; m_ok = 1;
      for (int i = 0; i < 16; i++) begin b_vld[i] = 0; b_ctr[i] = 1; end
    end else begin
      if (mis) begin
        m_fpc = et ? etg : epc + 4; m_valid = 0; m_inst = NOP;
      end else if (!st) begin
        m_pc = m_fpc; m_inst = mem_word(m_fpc); m_valid = 1; m_pt = ptk; m_ptgt = nxt; m_fpc = nxt;
      end
      if (ev) begin
        ui = (epc / 4) % 16;
        if (b_vld[ui] && b_tag[ui] == epc / 64) begin
          b_ctr[ui] = et ? (b_ctr[ui] < 3 ? b_ctr[ui] + 1 : 3) : (b_ctr[ui] > 0 ? b_ctr[ui] - 1 : 0);
          if (et) b_tgt[ui] = etg;
        end else if (et) begin
          b_vld[ui] = 1; b_tag[ui] = epc / 64; b_tgt[ui] = etg; b_ctr[ui] = 2;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input logic [31:0] epc, input bit et, input logic [31:0] etg);
    bit p;
    p = model_pred(epc);
    step(0, 0, 1, epc, et, etg, p, p ? etg : 32'h0);
  endtask

  initial begin
    reset = 1; stall = 0; ex_valid = 0; ex_pc = 0; ex_taken = 0;
    ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check_eq("reset_imem_addr", imem_addr, 32'd64);
    check_eq("reset_valid", valid, 0);
    check_eq("reset_inst", instruction, NOP);
    idle(4);

    // JAL 0x44 -> 0x0: first pass mispredicts and allocates, second predicts.
    step(0, 0, 1, 32'h44, 1, 32'h0, 0, 32'h0);
    begin : walk
      for (int i = 0; i < 40; i++) begin
        if (m_fpc == 32'h44) disable walk;
        idle(1);
      end
      check_eq("walk_to_0x44_timeout", m_fpc, 32'h44);
    end
    idle(1);
    @(posedge clk); #1;
    check_eq("jal_pc", pc, 32'h44);
    check_eq("jal_pred_taken", pred_taken, 1);
    check_eq("jal_pred_target", pred_target, 32'h0);
    check_eq("jal_redirect", imem_addr, 32'h0);
    check_eq("jal_no_flush", flush, 0);

    // BEQ at 0x0: counter walk up then down past the threshold.
    resolve(32'h0, 1, 32'h3C);
    resolve(32'h0, 1, 32'h3C);
    resolve(32'h0, 0, 32'h3C);
    resolve(32'h0, 0, 32'h3C);
    resolve(32'h0, 1, 32'h3C);

    // Stall, then mispredict arriving while stalled.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h20, 1, 32'h80, 0, 32'h0);
    idle(2);

    // Alias: 0x04 and 0x44 share an index with different tags.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h04, 1, 32'h100, 0, 32'h0);
    step(0, 0, 1, 32'h3C, 1, 32'h44, 0, 32'h0);
    idle(1);
    @(posedge clk); #1;
    check_eq("alias_pc", pc, 32'h44);
    check_eq("alias_pred_taken", pred_taken, 0);
    check_eq("alias_next", imem_addr, 32'h48);

    // Reset wins over a simultaneous mispredict.
    step(1, 0, 1, 32'h10, 1, 32'h200, 0, 32'h0);
    @(posedge clk); #1;
    check_eq("rst_mis_addr", imem_addr, 32'd64);
    check_eq("rst_mis_valid", valid, 0);
    idle(20);

    for (int n = 0; n < 3000; n++) begin
      bit          r, st, ev, et, ept;
      logic [31:0] epc, etg, eptg;
      r   = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 4) == 0);
      ev  = ($urandom_range(0, 2) == 0);
      epc = 32'($urandom_range(0, 63)) << 2;
      etg = 32'($urandom_range(0, 63)) << 2;
      et  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 6) begin
        ept = et; eptg = etg;
      end else begin
        ept = 1'($urandom_range(0, 1));
        eptg = ($urandom_range(0, 1) == 0) ? etg : 32'($urandom_range(0, 63)) << 2;
      end
      step(r, st, ev, epc, et, etg, ept, eptg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
